// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and helpers for the bit-serial adder.
// Latency: n/a (types only).
// Backpressure: n/a.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter width for a given operand width; it only has to reach WIDTH-1.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder: single-bit full adder cell used by the serial datapath.
// Latency: combinational.
// Backpressure: none.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial A+B+cin, one bit per clock LSB first, one FA cell.
// Latency: start accepted at edge E, done high between edges E+WIDTH and E+WIDTH+1.
// Backpressure: start ignored while busy; next start accepted at E+WIDTH+2 earliest.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic fa_s;
  logic fa_co;

  // The only arithmetic in the block: one bit of the sum per RUN cycle.
  full_adder u_fa (
    .x  (a_sr_q[0]),
    .y  (b_sr_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Next-state and datapath update; hold everything by default.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        // cout is left alone until the last bit so the previous result stays visible.
        if (cnt_q == CW'(WIDTH - 1)) begin
          cout_d  = fa_co;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder against A+B+cin.
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int total;
  int bad;
  int cyc;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle before looking at outputs or changing inputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and wait (bounded) for its done pulse.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                       output int lat, output int busy_n, output bit timed_out);
    a = av; b = bv; cin = ci; start = 1'b1;
    tick();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    lat = 0;
    busy_n = busy ? 1 : 0;
    timed_out = 1'b1;
    for (int k = 0; k < 64; k++) begin
      tick();
      lat++;
      if (busy) busy_n++;
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  logic [W:0] exp_res;
  logic [W-1:0] ra, rb;
  logic rc;
  int lat, busy_n, prev_done_cyc, extra;
  bit to;

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;

    // Reset then idle
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_busy", 64'(busy), 64'(0));
      check("idle_done", 64'(done), 64'(0));
      check("idle_sum",  64'(sum),  64'(0));
      check("idle_cout", 64'(cout), 64'(0));
    end

    // Basic add
    do_op(8'h35, 8'h4A, 1'b0, lat, busy_n, to);
    check("basic_timeout", 64'(to), 64'(0));
    check("basic_latency", 64'(lat), 64'(W));
    check("basic_sum", 64'(sum), 64'(8'h7F));
    check("basic_cout", 64'(cout), 64'(0));
    check("basic_busy_cycles", 64'(busy_n), 64'(W + 1));
    tick();
    check("basic_done_pulse", 64'(done), 64'(0));
    check("basic_busy_drop", 64'(busy), 64'(0));

    // Carry chain / overflow
    do_op(8'hFF, 8'h01, 1'b0, lat, busy_n, to);
    check("ovf1_timeout", 64'(to), 64'(0));
    check("ovf1_sum", 64'(sum), 64'(8'h00));
    check("ovf1_cout", 64'(cout), 64'(1));
    tick();
    do_op(8'hFF, 8'hFF, 1'b1, lat, busy_n, to);
    check("ovf2_timeout", 64'(to), 64'(0));
    check("ovf2_sum", 64'(sum), 64'(8'hFF));
    check("ovf2_cout", 64'(cout), 64'(1));
    tick();
    check("ovf2_hold_sum", 64'(sum), 64'(8'hFF));

    // Start ignored while busy
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    a = 8'hAA; b = 8'h55; start = 1'b1;
    tick();
    start = 1'b0;
    to = 1'b1;
    for (int k = 0; k < 64; k++) begin
      if (done) begin
        to = 1'b0;
        break;
      end
      tick();
    end
    check("busyign_timeout", 64'(to), 64'(0));
    check("busyign_sum", 64'(sum), 64'(8'h30));
    check("busyign_cout", 64'(cout), 64'(0));
    a = 8'hAA; b = 8'h55; start = 1'b1;
    tick();
    start = 1'b0;
    check("busyign_done_clear", 64'(done), 64'(0));
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) extra++;
      tick();
    end
    check("busyign_no_second_op", 64'(extra), 64'(0));
    do_op(8'hAA, 8'h55, 1'b0, lat, busy_n, to);
    check("busyign_next_timeout", 64'(to), 64'(0));
    check("busyign_next_sum", 64'(sum), 64'(8'hFF));
    tick();

    // Reset mid-operation
    a = 8'h81; b = 8'h81; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_sum", 64'(sum), 64'(0));
    check("midrst_cout", 64'(cout), 64'(0));
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done || busy) extra++;
    end
    check("midrst_no_done", 64'(extra), 64'(0));
    do_op(8'h02, 8'h03, 1'b0, lat, busy_n, to);
    check("midrst_next_timeout", 64'(to), 64'(0));
    check("midrst_next_sum", 64'(sum), 64'(8'h05));
    check("midrst_next_cout", 64'(cout), 64'(0));
    tick();

    // Back-to-back random operations
    prev_done_cyc = -1;
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      exp_res = (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc);
      do_op(ra, rb, rc, lat, busy_n, to);
      check("rnd_timeout", 64'(to), 64'(0));
      if (to) break;
      check("rnd_sum", 64'(sum), 64'(exp_res[W-1:0]));
      check("rnd_cout", 64'(cout), 64'(exp_res[W]));
      if (prev_done_cyc >= 0)
        check("rnd_done_spacing", 64'(cyc - prev_done_cyc), 64'(W + 2));
      prev_done_cyc = cyc;
      tick();
      check("rnd_done_pulse", 64'(done), 64'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
